// File: rtl/misc_pkg.sv
// Shared definitions for the MISC memory arbiter: host-slot state encoding
// and default widths.
package misc_pkg;

    localparam int MISC_L      = 16;
    localparam int MISC_STAT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_DONE = 2'd2
    } slot_state_e;

endpackage

// File: rtl/misc_host_slot.sv
// One-deep host request buffer with its IDLE/PEND/DONE sequencer; the
// transfer is issued in the first cycle the CPU leaves the memory free.
module misc_host_slot
    import misc_pkg::*;
#(
    parameter int l = MISC_L
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         host_req,
    input  logic         host_we,
    input  logic [l-1:0] host_addr,
    input  logic [l-1:0] host_wdata,
    input  logic         slot_free,
    input  logic [l-1:0] mem_rdata,
    output slot_state_e  state,
    output logic         buf_we,
    output logic [l-1:0] buf_addr,
    output logic [l-1:0] buf_wdata,
    output logic         host_ready,
    output logic         host_ack,
    output logic [l-1:0] host_rdata
);

    slot_state_e  state_q, state_d;
    logic         buf_we_q, buf_we_d;
    logic [l-1:0] buf_addr_q, buf_addr_d;
    logic [l-1:0] buf_wdata_q, buf_wdata_d;
    logic [l-1:0] rdata_q, rdata_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            buf_we_q    <= 1'b0;
            buf_addr_q  <= '0;
            buf_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            buf_we_q    <= buf_we_d;
            buf_addr_q  <= buf_addr_d;
            buf_wdata_q <= buf_wdata_d;
            rdata_q     <= rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        buf_we_d    = buf_we_q;
        buf_addr_d  = buf_addr_q;
        buf_wdata_d = buf_wdata_q;
        rdata_d     = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (host_req) begin
                    buf_we_d    = host_we;
                    buf_addr_d  = host_addr;
                    buf_wdata_d = host_wdata;
                    state_d     = ST_PEND;
                end
            end
            ST_PEND: begin
                if (slot_free) begin
                    // Writes leave the previously returned read data in place.
                    if (!buf_we_q) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Ready/ack decode straight from the state flop so an async reset clears them at once.
    assign state      = state_q;
    assign buf_we     = buf_we_q;
    assign buf_addr   = buf_addr_q;
    assign buf_wdata  = buf_wdata_q;
    assign host_ready = (state_q == ST_IDLE);
    assign host_ack   = (state_q == ST_DONE);
    assign host_rdata = rdata_q;

endmodule

// File: rtl/misc_mem_arbiter.sv
// Memory arbiter between the MISC CPU (absolute priority) and one host port.
// Optional statistics counters are enabled by defining MISC_ARB_STAT_EN.
module misc_mem_arbiter
    import misc_pkg::*;
#(
    parameter int l      = MISC_L,
    parameter int STAT_W = MISC_STAT_W
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [l-1:0] cpu_addr,
    inout  wire  [l-1:0] cpu_data,
    input  logic         cpu_csel,
    input  logic         cpu_rw,
    output logic [l-1:0] mem_addr,
    output logic [l-1:0] mem_wdata,
    output logic         mem_we,
    input  logic [l-1:0] mem_rdata,
    input  logic         host_req,
    input  logic         host_we,
    input  logic [l-1:0] host_addr,
    input  logic [l-1:0] host_wdata,
    output logic         host_ready,
    output logic         host_ack,
    output logic [l-1:0] host_rdata
`ifdef MISC_ARB_STAT_EN
    ,
    output logic [STAT_W-1:0] stat_xfers,
    output logic [STAT_W-1:0] stat_wait
`endif
);

    slot_state_e  slot_state;
    logic         buf_we;
    logic [l-1:0] buf_addr;
    logic [l-1:0] buf_wdata;
    logic         host_sel;

    misc_host_slot #(
        .l (l)
    ) u_slot (
        .clock      (clock),
        .reset_n    (reset_n),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .slot_free  (!cpu_csel),
        .mem_rdata  (mem_rdata),
        .state      (slot_state),
        .buf_we     (buf_we),
        .buf_addr   (buf_addr),
        .buf_wdata  (buf_wdata),
        .host_ready (host_ready),
        .host_ack   (host_ack),
        .host_rdata (host_rdata)
    );

    // The host only owns the memory in a pending cycle the CPU has left free.
    assign host_sel = (slot_state == ST_PEND) && !cpu_csel;

    always_comb begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_data;
        mem_we    = !cpu_rw && cpu_csel;
        if (host_sel) begin
            mem_addr  = buf_addr;
            mem_wdata = buf_wdata;
            mem_we    = buf_we;
        end
    end

    assign cpu_data = (cpu_rw && cpu_csel) ? mem_rdata : {l{1'bz}};

    if (STAT_W < 1) begin : g_bad_stat_w
    end

`ifdef MISC_ARB_STAT_EN
    logic [STAT_W-1:0] xfers_q, xfers_d;
    logic [STAT_W-1:0] wait_q, wait_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            xfers_q <= '0;
            wait_q  <= '0;
        end else begin
            xfers_q <= xfers_d;
            wait_q  <= wait_d;
        end
    end

    // Both counters stick at all-ones rather than wrapping.
    always_comb begin
        xfers_d = xfers_q;
        wait_d  = wait_q;
        if ((slot_state == ST_DONE) && !(&xfers_q)) begin
            xfers_d = xfers_q + STAT_W'(1);
        end
        if ((slot_state == ST_PEND) && cpu_csel && !(&wait_q)) begin
            wait_d = wait_q + STAT_W'(1);
        end
    end

    assign stat_xfers = xfers_q;
    assign stat_wait  = wait_q;
`endif

endmodule

// File: tb/tb_misc_mem_arbiter.sv
// Directed bench for misc_mem_arbiter: vector table plus hand sequences for
// latency, reset during a pending request and the optional counters.
module tb_misc_mem_arbiter;

    logic        clock;
    logic        reset_n;
    logic [15:0] cpu_addr;
    wire  [15:0] cpu_data;
    logic        cpu_csel;
    logic        cpu_rw;
    logic [15:0] cpu_wdata;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic [15:0] mem_rdata;
    logic        host_req;
    logic        host_we;
    logic [15:0] host_addr;
    logic [15:0] host_wdata;
    logic        host_ready;
    logic        host_ack;
    logic [15:0] host_rdata;
`ifdef MISC_ARB_STAT_EN
    logic [2:0]  stat_xfers;
    logic [2:0]  stat_wait;
`endif

    int checks;
    int errors;

    logic [15:0] mem [0:255];
    logic        load_en;
    logic [7:0]  load_addr;
    logic [15:0] load_data;

    assign cpu_data  = (!cpu_rw) ? cpu_wdata : 16'bz;
    assign mem_rdata = mem[mem_addr[7:0]];

    always @(posedge clock) begin
        if (load_en) mem[load_addr] <= load_data;
        else if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    end

    misc_mem_arbiter #(
        .l      (16),
        .STAT_W (3)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .cpu_addr   (cpu_addr),
        .cpu_data   (cpu_data),
        .cpu_csel   (cpu_csel),
        .cpu_rw     (cpu_rw),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_ready (host_ready),
        .host_ack   (host_ack),
        .host_rdata (host_rdata)
`ifdef MISC_ARB_STAT_EN
        ,
        .stat_xfers (stat_xfers),
        .stat_wait  (stat_wait)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        csel;
        logic        rw;
        logic [15:0] caddr;
        logic [15:0] cwdata;
        logic        req;
        logic        hwe;
        logic [15:0] haddr;
        logic [15:0] hwdata;
        logic [15:0] e_maddr;
        logic        e_we;
        logic        e_ready;
        logic        e_ack;
        logic [15:0] e_rdata;
    } vec_t;

    vec_t vecs [12];

    function automatic vec_t mk(input logic csel, input logic rw, input logic [15:0] caddr,
                                input logic [15:0] cwdata, input logic req, input logic hwe,
                                input logic [15:0] haddr, input logic [15:0] hwdata,
                                input logic [15:0] e_maddr, input logic e_we, input logic e_ready,
                                input logic e_ack, input logic [15:0] e_rdata);
        vec_t v;
        v.csel = csel; v.rw = rw; v.caddr = caddr; v.cwdata = cwdata;
        v.req = req; v.hwe = hwe; v.haddr = haddr; v.hwdata = hwdata;
        v.e_maddr = e_maddr; v.e_we = e_we; v.e_ready = e_ready;
        v.e_ack = e_ack; v.e_rdata = e_rdata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic quick_read(input logic [15:0] addr, input logic [15:0] exp_data);
        int cnt;
        @(negedge clock);
        host_req = 1'b1; host_we = 1'b0; host_addr = addr;
        cpu_csel = 1'b0; cpu_rw = 1'b1; cpu_addr = 16'h0010;
        @(negedge clock);
        host_req = 1'b0;
        #1;
        chk("q_pend_ack", {31'd0, host_ack}, 32'd0);
        cnt = 0;
        while (!host_ack && cnt < 8) begin
            @(negedge clock);
            #1;
            cnt++;
        end
        chk("q_ack_latency", cnt, 32'd1);
        chk("q_rdata", {16'd0, host_rdata}, {16'd0, exp_data});
        @(negedge clock);
        #1;
        chk("q_ack_one_cycle", {31'd0, host_ack}, 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset_n = 1'b0;
        cpu_addr = 16'h0010; cpu_csel = 1'b0; cpu_rw = 1'b1; cpu_wdata = 16'h0000;
        host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0020; host_wdata = 16'h7777;
        load_en = 1'b0; load_addr = 8'h00; load_data = 16'h0000;

        vecs[0]  = mk(1, 1, 16'h0010, 16'h0000, 1, 1, 16'h0040, 16'hBEEF, 16'h0010, 0, 1, 0, 16'h0000);
        vecs[1]  = mk(1, 1, 16'h0010, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0010, 0, 0, 0, 16'h0000);
        vecs[2]  = mk(1, 1, 16'h0010, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0010, 0, 0, 0, 16'h0000);
        vecs[3]  = mk(1, 1, 16'h0010, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0010, 0, 0, 0, 16'h0000);
        vecs[4]  = mk(0, 1, 16'h0010, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0040, 1, 0, 0, 16'h0000);
        vecs[5]  = mk(0, 1, 16'h0010, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0010, 0, 0, 1, 16'h0000);
        vecs[6]  = mk(1, 0, 16'h0050, 16'h1234, 1, 0, 16'h0040, 16'h0000, 16'h0050, 1, 1, 0, 16'h0000);
        vecs[7]  = mk(1, 1, 16'h0050, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0050, 0, 0, 0, 16'h0000);
        vecs[8]  = mk(1, 1, 16'h0050, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0050, 0, 0, 0, 16'h0000);
        vecs[9]  = mk(0, 1, 16'h0010, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0040, 0, 0, 0, 16'h0000);
        vecs[10] = mk(0, 1, 16'h0010, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0010, 0, 0, 1, 16'hBEEF);
        vecs[11] = mk(0, 1, 16'h0010, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0010, 0, 1, 0, 16'hBEEF);

        // Preload the bench memory while reset is held.
        @(negedge clock); load_en = 1'b1; load_addr = 8'h10; load_data = 16'h5A5A;
        @(negedge clock); load_addr = 8'h40; load_data = 16'h0000;
        @(negedge clock); load_addr = 8'h60; load_data = 16'h1111;
        @(negedge clock); load_en = 1'b0;
        #1;
        chk("rst_ready", {31'd0, host_ready}, 32'd1);
        chk("rst_ack", {31'd0, host_ack}, 32'd0);
        chk("rst_rdata", {16'd0, host_rdata}, 32'd0);
        chk("rst_mem_addr", {16'd0, mem_addr}, 32'h0010);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        checks++;
        if (cpu_data === mem_rdata) begin
            errors++;
            $display("FAIL rst_cpu_data_z: got %h expected z", cpu_data);
        end else begin
            $display("ok   rst_cpu_data_z: %h", cpu_data);
        end
`ifdef MISC_ARB_STAT_EN
        chk("rst_stat_xfers", {29'd0, stat_xfers}, 32'd0);
        chk("rst_stat_wait", {29'd0, stat_wait}, 32'd0);
`endif
        host_req = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            cpu_csel = vecs[i].csel; cpu_rw = vecs[i].rw;
            cpu_addr = vecs[i].caddr; cpu_wdata = vecs[i].cwdata;
            host_req = vecs[i].req; host_we = vecs[i].hwe;
            host_addr = vecs[i].haddr; host_wdata = vecs[i].hwdata;
            #1;
            $display("vec %0d: mem_addr=%h we=%b ready=%b ack=%b rdata=%h",
                     i, mem_addr, mem_we, host_ready, host_ack, host_rdata);
            chk($sformatf("v%0d_mem_addr", i), {16'd0, mem_addr}, {16'd0, vecs[i].e_maddr});
            chk($sformatf("v%0d_mem_we", i), {31'd0, mem_we}, {31'd0, vecs[i].e_we});
            chk($sformatf("v%0d_ready", i), {31'd0, host_ready}, {31'd0, vecs[i].e_ready});
            chk($sformatf("v%0d_ack", i), {31'd0, host_ack}, {31'd0, vecs[i].e_ack});
            chk($sformatf("v%0d_rdata", i), {16'd0, host_rdata}, {16'd0, vecs[i].e_rdata});
            if (i == 4) chk("v4_mem_wdata", {16'd0, mem_wdata}, 32'hBEEF);
            if (i == 6) chk("v6_mem_wdata", {16'd0, mem_wdata}, 32'h1234);
            if (i == 7) chk("v7_cpu_read", {16'd0, cpu_data}, 32'h1234);
        end
        chk("mem40_written", {16'd0, mem[8'h40]}, 32'hBEEF);

`ifdef MISC_ARB_STAT_EN
        chk("stat_xfers_2", {29'd0, stat_xfers}, 32'd2);
        chk("stat_wait_5", {29'd0, stat_wait}, 32'd5);
`endif

        // Back-to-back minimum-latency reads; six more transfers push a 3-bit counter past 7.
        for (int k = 0; k < 6; k++) begin
            quick_read(16'h0050, 16'h1234);
        end
`ifdef MISC_ARB_STAT_EN
        chk("stat_xfers_sat", {29'd0, stat_xfers}, 32'd7);
        chk("stat_wait_hold", {29'd0, stat_wait}, 32'd5);
`endif

        // Reset while a host write is pending must drop it.
        @(negedge clock);
        cpu_csel = 1'b1; cpu_rw = 1'b1; cpu_addr = 16'h0010;
        host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0060; host_wdata = 16'hAAAA;
        @(negedge clock);
        host_req = 1'b0;
        #1;
        chk("midpend_ready", {31'd0, host_ready}, 32'd0);
        reset_n = 1'b0;
        #1;
        chk("midpend_rst_ready", {31'd0, host_ready}, 32'd1);
        chk("midpend_rst_ack", {31'd0, host_ack}, 32'd0);
        @(negedge clock);
        cpu_csel = 1'b0;
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("after_rst_ack_%0d", k), {31'd0, host_ack}, 32'd0);
            chk($sformatf("after_rst_we_%0d", k), {31'd0, mem_we}, 32'd0);
            @(negedge clock);
        end
        chk("mem60_unchanged", {16'd0, mem[8'h60]}, 32'h1111);
`ifdef MISC_ARB_STAT_EN
        chk("stat_xfers_cleared", {29'd0, stat_xfers}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
